// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// =============================================================================
// regfile_write_arbiter
//   Round-robin sharing of the register-file write port between requesters A/B,
//   registered onto W_En/W_Addr/W_Data. Optional clear sequencer: REGFILE_ARB_CLEAR_EN.
// Revision: 1.0
// =============================================================================
module regfile_write_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              A_Req,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_Data,
    output logic              A_Gnt,
    input  logic              B_Req,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_Data,
    output logic              B_Gnt,
    input  logic              Clr_Start,
    output logic              Busy,
    output logic              W_En,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data
);

    logic              r_prio;      // 0: A wins a tie, 1: B wins a tie
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_clr_go;
    logic              w_in_clear;
    logic [ADDR_W-1:0] w_clr_addr;

`ifdef REGFILE_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) begin
            if (Clr_Start) begin
                w_state_nxt = CLEAR;
            end
        end else begin
            if (r_cnt == C_LAST_ADDR) begin
                w_state_nxt = IDLE;
            end
        end
    end

    assign w_in_clear = (r_state == CLEAR);
    assign w_clr_go   = (r_state == IDLE) && Clr_Start;
    assign w_clr_addr = r_cnt;
`else
    logic w_unused_clr_start;
    assign w_unused_clr_start = Clr_Start;
    assign w_in_clear         = 1'b0;
    assign w_clr_go           = 1'b0;
    assign w_clr_addr         = '0;
`endif

    // A clear request in the same cycle pre-empts any grant.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!Rst && !w_in_clear && !w_clr_go) begin
            if (A_Req && (!B_Req || !r_prio)) begin
                w_a_gnt = 1'b1;
            end else if (B_Req) begin
                w_b_gnt = 1'b1;
            end
        end
    end

    assign A_Gnt = w_a_gnt;
    assign B_Gnt = w_b_gnt;
    assign Busy  = w_in_clear;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            W_En   <= 1'b0;
            W_Addr <= '0;
            W_Data <= '0;
            r_prio <= 1'b0;
        end else if (w_in_clear) begin
            W_En   <= 1'b1;
            W_Addr <= w_clr_addr;
            W_Data <= '0;
        end else if (w_a_gnt) begin
            W_En   <= 1'b1;
            W_Addr <= A_Addr;
            W_Data <= A_Data;
            r_prio <= 1'b1;
        end else if (w_b_gnt) begin
            W_En   <= 1'b1;
            W_Addr <= B_Addr;
            W_Data <= B_Data;
            r_prio <= 1'b0;
        end else begin
            W_En   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// =============================================================================
// tb_regfile_write_arbiter
//   Vector table, hand sequences and randomized model check of the write arbiter.
// Revision: 1.0
// =============================================================================
module tb_regfile_write_arbiter;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              A_Req, B_Req, A_Gnt, B_Gnt;
    logic [ADDR_W-1:0] A_Addr, B_Addr, W_Addr;
    logic [DATA_W-1:0] A_Data, B_Data, W_Data;
    logic              Clr_Start, Busy, W_En;

    logic [DATA_W-1:0] rf [NUM_REGS];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .A_Req(A_Req), .A_Addr(A_Addr), .A_Data(A_Data), .A_Gnt(A_Gnt),
        .B_Req(B_Req), .B_Addr(B_Addr), .B_Data(B_Data), .B_Gnt(B_Gnt),
        .Clr_Start(Clr_Start), .Busy(Busy),
        .W_En(W_En), .W_Addr(W_Addr), .W_Data(W_Data)
    );

    // Register file stand-in driven by the arbiter's write port.
    always @(posedge Clk) begin
        if (W_En) rf[W_Addr] <= W_Data;
    end

    typedef struct {
        logic              a_req;
        logic [ADDR_W-1:0] a_addr;
        logic [DATA_W-1:0] a_data;
        logic              b_req;
        logic [ADDR_W-1:0] b_addr;
        logic [DATA_W-1:0] b_data;
        logic              exp_a;
        logic              exp_b;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic br, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                         input logic clr);
        A_Req = ar; A_Addr = aa; A_Data = ad;
        B_Req = br; B_Addr = ba; B_Data = bd;
        Clr_Start = clr;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();
        Rst = 1'b0;
    endtask

    task automatic check_w(input string tag, input logic en, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] da);
        check({tag, "_w_en"}, 64'(W_En), 64'(en));
        check({tag, "_w_addr"}, 64'(W_Addr), 64'(ad));
        check({tag, "_w_data"}, 64'(W_Data), 64'(da));
    endtask

    // Preload register i with 100+i through requester A alone.
    task automatic preload();
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(1, ADDR_W'(i), DATA_W'(100 + i), 0, 0, 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    // Reference model state for randomized traffic.
    logic              m_a_pend, m_b_pend;
    logic [ADDR_W-1:0] m_a_addr, m_b_addr;
    logic [DATA_W-1:0] m_a_data, m_b_data;
    int                m_last;          // 0: A granted most recently, 1: B (or none yet)
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [DATA_W-1:0] m_rf [NUM_REGS];
    logic              m_rf_vld [NUM_REGS];

    initial begin
        //                 a_req a_addr a_data b_req b_addr b_data expA expB
        tbl[0]  = '{0, 3'd0, 32'd0,   0, 3'd0, 32'd0,   0, 0};
        tbl[1]  = '{0, 3'd0, 32'd0,   1, 3'd5, 32'd666, 0, 1};
        tbl[2]  = '{1, 3'd0, 32'd33,  1, 3'd0, 32'd1,   1, 0};
        tbl[3]  = '{1, 3'd3, 32'd111, 1, 3'd0, 32'd1,   0, 1};
        tbl[4]  = '{1, 3'd3, 32'd111, 1, 3'd5, 32'd666, 1, 0};
        tbl[5]  = '{1, 3'd3, 32'd111, 1, 3'd5, 32'd666, 0, 1};
        tbl[6]  = '{1, 3'd3, 32'd111, 1, 3'd5, 32'd666, 1, 0};
        tbl[7]  = '{0, 3'd0, 32'd0,   1, 3'd5, 32'd666, 0, 1};
        tbl[8]  = '{0, 3'd0, 32'd0,   1, 3'd6, 32'd7,   0, 1};
        tbl[9]  = '{0, 3'd0, 32'd0,   1, 3'd6, 32'd8,   0, 1};
        tbl[10] = '{1, 3'd1, 32'd10,  1, 3'd6, 32'd9,   1, 0};
        tbl[11] = '{1, 3'd2, 32'd20,  1, 3'd6, 32'd9,   0, 1};
        tbl[12] = '{1, 3'd2, 32'd20,  0, 3'd0, 32'd0,   1, 0};
        tbl[13] = '{0, 3'd0, 32'd0,   0, 3'd0, 32'd0,   0, 0};

        // Reset with A already requesting: no grant may leak through.
        Rst = 1'b1;
        drive(1, 3'd2, 32'd321, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge Clk);
            check("rst_a_gnt", 64'(A_Gnt), 64'd0);
            check("rst_b_gnt", 64'(B_Gnt), 64'd0);
            next_cycle();
        end
        Rst = 1'b0;
        @(negedge Clk);
        check_w("rst", 1'b0, 3'd0, 32'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("first_a_gnt", 64'(A_Gnt), 64'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        check_w("first", 1'b1, 3'd2, 32'd321);
        next_cycle();
        @(negedge Clk);
        check("readback_r2", 64'(rf[2]), 64'd321);

        // Vector table: priority now favours B.
        e_en = 1'b0; e_addr = 3'd2; e_data = 32'd321;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].a_req, tbl[i].a_addr, tbl[i].a_data,
                  tbl[i].b_req, tbl[i].b_addr, tbl[i].b_data, 0);
            @(negedge Clk);
            check($sformatf("tbl%0d_a_gnt", i), 64'(A_Gnt), 64'(tbl[i].exp_a));
            check($sformatf("tbl%0d_b_gnt", i), 64'(B_Gnt), 64'(tbl[i].exp_b));
            check_w($sformatf("tbl%0d", i), e_en, e_addr, e_data);
            if (tbl[i].exp_a) begin
                e_en = 1'b1; e_addr = tbl[i].a_addr; e_data = tbl[i].a_data;
            end else if (tbl[i].exp_b) begin
                e_en = 1'b1; e_addr = tbl[i].b_addr; e_data = tbl[i].b_data;
            end else begin
                e_en = 1'b0;
            end
            next_cycle();
        end
        @(negedge Clk);
        check("tbl_r0_last_wins", 64'(rf[0]), 64'd1);
        check("tbl_r2", 64'(rf[2]), 64'd20);
        check("tbl_r3", 64'(rf[3]), 64'd111);
        check("tbl_r6", 64'(rf[6]), 64'd9);

        // Randomized traffic against a round-robin model; requesters hold until granted.
        do_reset();
        m_a_pend = 0; m_b_pend = 0; m_a_addr = '0; m_b_addr = '0; m_a_data = '0; m_b_data = '0;
        m_last = 1;
        e_en = 1'b0; e_addr = '0; e_data = '0;
        for (int i = 0; i < NUM_REGS; i++) m_rf_vld[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int win;
            if (!m_a_pend && ($urandom % 3 != 0)) begin
                m_a_pend = 1; m_a_addr = ADDR_W'($urandom_range(0, NUM_REGS - 1)); m_a_data = $urandom;
            end
            if (!m_b_pend && ($urandom % 3 != 0)) begin
                m_b_pend = 1; m_b_addr = ADDR_W'($urandom_range(0, NUM_REGS - 1)); m_b_data = $urandom;
            end
            drive(m_a_pend, m_a_addr, m_a_data, m_b_pend, m_b_addr, m_b_data, 0);
            if (m_a_pend && m_b_pend) win = (m_last == 1) ? 0 : 1;
            else if (m_a_pend)        win = 0;
            else if (m_b_pend)        win = 1;
            else                      win = -1;
            @(negedge Clk);
            check("rnd_a_gnt", 64'(A_Gnt), 64'(win == 0));
            check("rnd_b_gnt", 64'(B_Gnt), 64'(win == 1));
            check_w("rnd", e_en, e_addr, e_data);
            if (win == 0) begin
                e_en = 1; e_addr = m_a_addr; e_data = m_a_data; m_a_pend = 0; m_last = 0;
            end else if (win == 1) begin
                e_en = 1; e_addr = m_b_addr; e_data = m_b_data; m_b_pend = 0; m_last = 1;
            end else begin
                e_en = 0;
            end
            if (e_en) begin
                m_rf[e_addr] = e_data; m_rf_vld[e_addr] = 1'b1;
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();
        for (int i = 0; i < NUM_REGS; i++) begin
            if (m_rf_vld[i]) check($sformatf("rnd_rf%0d", i), 64'(rf[i]), 64'(m_rf[i]));
        end

`ifdef REGFILE_ARB_CLEAR_EN
        // Clear sequence with a pending A request.
        do_reset();
        preload();
        drive(1, 3'd4, 32'd55, 0, 0, 0, 1);
        @(negedge Clk);
        check("clr_start_a_gnt", 64'(A_Gnt), 64'd0);
        check("clr_start_busy", 64'(Busy), 64'd0);
        next_cycle();
        Clr_Start = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            @(negedge Clk);
            check($sformatf("clr%0d_busy", i), 64'(Busy), 64'd1);
            check($sformatf("clr%0d_a_gnt", i), 64'(A_Gnt), 64'd0);
            check($sformatf("clr%0d_w_en", i), 64'(W_En), 64'(i > 0));
            if (i > 0) begin
                check($sformatf("clr%0d_w_addr", i), 64'(W_Addr), 64'(i - 1));
                check($sformatf("clr%0d_w_data", i), 64'(W_Data), 64'd0);
            end
            Clr_Start = (i == 3);   // a restart attempt mid-clear must be ignored
            next_cycle();
        end
        Clr_Start = 1'b0;
        @(negedge Clk);
        check("clr_end_busy", 64'(Busy), 64'd0);
        check("clr_end_a_gnt", 64'(A_Gnt), 64'd1);
        check_w("clr_last", 1'b1, 3'd7, 32'd0);
        next_cycle();
        A_Req = 1'b0;
        @(negedge Clk);
        check_w("clr_after", 1'b1, 3'd4, 32'd55);
        next_cycle();
        @(negedge Clk);
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("clr_rf%0d", i), 64'(rf[i]), (i == 4) ? 64'd55 : 64'd0);
        end

        // Reset during clear cycle 4: registers 4..7 keep their preload.
        preload();
        drive(0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        Clr_Start = 1'b0;
        repeat (4) next_cycle();
        Rst = 1'b1;
        next_cycle();
        Rst = 1'b0;
        @(negedge Clk);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_w_en", 64'(W_En), 64'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("abort_rf%0d", i), 64'(rf[i]), (i < 4) ? 64'd0 : 64'(100 + i));
        end
`else
        // Without the clear feature Clr_Start is inert.
        do_reset();
        drive(1, 3'd1, 32'd5, 1, 3'd2, 32'd6, 1);
        @(negedge Clk);
        check("noclr_busy", 64'(Busy), 64'd0);
        check("noclr_a_gnt", 64'(A_Gnt), 64'd1);
        check("noclr_b_gnt", 64'(B_Gnt), 64'd0);
        next_cycle();
        drive(0, 3'd1, 32'd5, 1, 3'd2, 32'd6, 1);
        @(negedge Clk);
        check("noclr_busy2", 64'(Busy), 64'd0);
        check("noclr_b_gnt2", 64'(B_Gnt), 64'd1);
        check_w("noclr", 1'b1, 3'd1, 32'd5);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        check_w("noclr2", 1'b1, 3'd2, 32'd6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
